// File: rtl/bootrom_reader.sv
// bootrom_reader: reads consecutive 64-bit boot ROM words into a small FIFO
// and hands them to a valid/ready consumer, hiding ROM wait states.
module bootrom_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [17:0] base_adr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cs,
  output logic        cyc,
  output logic [17:0] adr,
  input  logic        ack,
  input  logic [63:0] dat_i,
  output logic [63:0] dout,
  output logic        dout_vld,
  input  logic        dout_rdy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    FIN
  } state_e;

  state_e        state_q;
  logic          cs_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [17:0]   adr_q;
  logic [15:0]   rem_q;
  logic [7:0]    tmo_q;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic push;
  logic pop;
  logic has_slot;
  logic unused;

  assign unused   = ^base_adr[2:0];
  assign has_slot = cnt_q != FULL;
  assign push     = (state_q == REQ) & ack & ~abort;
  assign pop      = dout_vld & dout_rdy & ~abort;

  assign cs       = cs_q;
  assign cyc      = cs_q;
  assign adr      = adr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dout_vld = cnt_q != '0;
  assign dout     = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (abort) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // REQ is only entered with a free slot, so an ack can always be pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cs_q    <= 1'b0;
        busy_q  <= 1'b0;
        rem_q   <= '0;
        tmo_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              adr_q <= {base_adr[17:3], 3'b000};
              rem_q <= count;
              err_q <= 1'b0;
              tmo_q <= '0;
              if (count == '0) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else if (has_slot) begin
                state_q <= REQ;
                cs_q    <= 1'b1;
                busy_q  <= 1'b1;
              end else begin
                state_q <= GAP;
                busy_q  <= 1'b1;
              end
            end
          end
          REQ: begin
            if (ack) begin
              adr_q   <= adr_q + 18'd8;
              rem_q   <= rem_q - 16'd1;
              tmo_q   <= '0;
              cs_q    <= 1'b0;
              state_q <= GAP;
            end else if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              cs_q    <= 1'b0;
              busy_q  <= 1'b0;
              tmo_q   <= '0;
              state_q <= IDLE;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end
          // Stale acks arrive here while cyc is low; GAP never looks at ack.
          GAP: begin
            if (rem_q == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (has_slot) begin
              state_q <= REQ;
              cs_q    <= 1'b1;
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bootrom_reader.md
# bootrom_reader

Bus-initiator read engine for the 64-bit boot ROM port. On a start pulse it fetches a programmed number of consecutive 64-bit words from a base address using the ROM's cs/cyc/ack handshake, buffers them in a small FIFO, and presents them to a downstream consumer over valid/ready. It sits between the boot ROM and boot-time copy/loader logic, so that logic never deals with ROM wait states directly.

## Interface
- FIFO_DEPTH, 4: FIFO entries, power of two, ≥2
- TIMEOUT, 255: max cycles in REQ without ack before error (8-bit counter)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- abort  in  1  abandon transfer, flush FIFO
- base_adr  in  18  byte address of first word; bits [2:0] ignored
- count  in  16  number of 64-bit words; 0 = empty transfer
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: transfer complete
- err  out  1  sticky timeout flag, cleared by next accepted start
- cs  out  1  ROM select
- cyc  out  1  bus cycle active (always equal to cs)
- adr  out  18  ROM byte address, bits [2:0] = 0
- ack  in  1  ROM acknowledge; dat_i valid when high
- dat_i  in  64  ROM read data
- dout  out  64  FIFO head word
- dout_vld  out  1  FIFO not empty
- dout_rdy  in  1  consumer pop; pop occurs when dout_vld & dout_rdy

## Operation
- States: IDLE, REQ, GAP, FIN.
- IDLE: start=1 latches adr←{base_adr[17:3],3'b0}, remaining←count, clears err, timeout counter←0. count=0 → FIN; else → REQ if FIFO has a free slot, otherwise GAP.
- REQ: cs=cyc=1, adr held. On ack: push dat_i, adr←adr+8 (wraps modulo 2^18), remaining−1, → GAP. Timeout counter increments each REQ cycle without ack; reaching TIMEOUT → err=1, cs/cyc drop, → IDLE, no done pulse, FIFO contents kept.
- GAP: cs=cyc=0 for ≥1 cycle (mandatory: ROM ack pipeline holds a stale ack one cycle after cyc drops). remaining=0 → FIN. Else → REQ when FIFO occupancy < FIFO_DEPTH; else stays in GAP.
- FIN: done=1 for exactly this cycle, → IDLE.
- At most one read outstanding; a REQ is entered only with a free FIFO slot reserved, so a push is never dropped.
- abort (any state): next cycle cs=cyc=0, state IDLE, FIFO emptied, remaining cleared, no done; err unchanged. abort has priority over start and ack in the same cycle.
- start outside IDLE ignored. Parameters of an accepted start are latched; later changes to base_adr/count have no effect.
- FIFO: simultaneous push and pop allowed at any occupancy (incl. full: pop frees slot, push is never attempted when full). No fall-through: pushed word visible on dout the cycle after ack.
- busy=1 in REQ and GAP; 0 in IDLE and FIN.
- Reset: state IDLE, cs=cyc=0, adr=0, busy=0, done=0, err=0, FIFO empty, dout_vld=0, dout=0.

## Timing
- start high in cycle 0 → cs/cyc high cycle 1; ROM ack cycle 3; dout_vld cycle 4.
- Sustained rate with consumer always ready: one word per 4 cycles (REQ 3 cycles incl. ack cycle, GAP 1).
- Last ack in cycle n → GAP n+1 → done pulse n+2, busy low from n+2.
- count=0: start cycle 0 → done cycle 1, no bus activity, busy never high.
- Timeout: cs/cyc low the cycle after the TIMEOUT-th waiting cycle; err high the same cycle.
- Reset asserted mid-transfer: cs/cyc drop immediately (asynchronous), no done.

## Test plan
- base_adr=0x00010, count=3, ROM model with 2-cycle ack, consumer always ready → adr sequence 0x10,0x18,0x20; dout = ROM[2],ROM[3],ROM[4]; cyc low exactly 1 cycle between reads; done once, 2 cycles after final ack.
- count=6, FIFO_DEPTH=4, dout_rdy=0 → exactly 4 reads, engine stalls in GAP with cyc=0; raise dout_rdy → remaining 2 read; 6 words in order, none lost or duplicated.
- base_adr=0x3FFF8, count=2 → adr 0x3FFF8 then 0x00000 (wrap); data ROM[32767], ROM[0].
- count=0 start → done pulse next cycle, cs/cyc never high, busy stays 0.
- ROM never acks, TIMEOUT=255 → cs/cyc drop after 255 REQ cycles, err=1 sticky, no done; next start clears err.
- abort while cyc high with 2 words buffered → cyc low next cycle, dout_vld=0, busy=0; a late ack from ROM is ignored; subsequent start runs normally.
